// File: rtl/fp16_mul_arbiter.sv
// fp16_mul_arbiter: round-robin sharing of one fixed-latency fp16 multiplier among NUM_REQ requesters,
// with an ID tag pipeline and a credit-protected response FIFO.
module fp16_mul_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int MUL_LAT = 2,
   parameter int FIFO_DEPTH = 4,
   localparam int ID_W = $clog2(NUM_REQ)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NUM_REQ-1:0]   req_valid,
   output logic [NUM_REQ-1:0]   req_ready,
   input  logic [16*NUM_REQ-1:0] req_a,
   input  logic [16*NUM_REQ-1:0] req_b,
   output logic [15:0]          mul_a,
   output logic [15:0]          mul_b,
   input  logic [15:0]          mul_out,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [ID_W-1:0]      rsp_id,
   output logic [15:0]          rsp_data,
   output logic                 busy,
   output logic [31:0]          issue_cnt
);
   localparam int PW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH + 1);

   logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d, gnt_id;
   logic             gnt_any, can_issue, push, pop;
   logic [MUL_LAT-1:0] vld_q;
   logic [ID_W-1:0]  id_q [MUL_LAT];
   logic [ID_W+15:0] mem_q [FIFO_DEPTH];
   logic [PW-1:0]    wr_q, rd_q;
   logic [CW-1:0]    cnt_q;
   logic [31:0]      issue_q;

   // The multiplier cannot stall, so every in-flight op must already own a FIFO slot.
   always_comb begin
      gnt_any = 1'b0;
      gnt_id = '0;
      can_issue = rst_n && (int'(cnt_q) + $countones(vld_q) < FIFO_DEPTH);
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (can_issue && req_valid[(int'(rr_ptr_q) + k) % NUM_REQ]) begin
            gnt_any = 1'b1;
            gnt_id = ID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
         end
      end
   end

   assign req_ready = {{(NUM_REQ-1){1'b0}}, gnt_any} << gnt_id;
   assign mul_a = gnt_any ? req_a[16*gnt_id +: 16] : 16'h0000;
   assign mul_b = gnt_any ? req_b[16*gnt_id +: 16] : 16'h0000;
   assign rr_ptr_d = gnt_any ? (gnt_id == ID_W'(NUM_REQ - 1) ? '0 : gnt_id + 1'b1) : rr_ptr_q;
   assign push = vld_q[MUL_LAT-1];
   assign rsp_valid = cnt_q != '0;
   assign pop = rsp_valid & rsp_ready;
   assign {rsp_id, rsp_data} = rsp_valid ? mem_q[rd_q] : '0;
   assign busy = (|vld_q) | rsp_valid;
   assign issue_cnt = issue_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr_q <= '0;
         vld_q <= '0;
         for (int k = 0; k < MUL_LAT; k++) id_q[k] <= '0;
         wr_q <= '0;
         rd_q <= '0;
         cnt_q <= '0;
         issue_q <= '0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
         vld_q <= MUL_LAT'({vld_q, gnt_any});
         id_q[0] <= gnt_id;
         for (int k = 1; k < MUL_LAT; k++) id_q[k] <= id_q[k-1];
         issue_q <= issue_q + 32'(gnt_any);
         if (push) wr_q <= (wr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wr_q + 1'b1;
         if (pop) rd_q <= (rd_q == PW'(FIFO_DEPTH - 1)) ? '0 : rd_q + 1'b1;
         cnt_q <= cnt_q + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_q] <= {id_q[MUL_LAT-1], mul_out};
   end
endmodule
